a2s_controller: RTL and testbench

A2S_CONTROLLER -- requirements
Module: a2s_controller

---
 rtl/a2s_controller_pkg.sv | 25 ++
 rtl/a2s_controller_if.sv | 19 +
 rtl/a2s_controller.sv | 120 ++++++++++++
 tb/tb_a2s_controller.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/a2s_controller_pkg.sv
// Shared types and constants for the OCM-to-stream read controller.
package a2s_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2
  } state_e;

  localparam int          BURST_LEN     = 16;
  localparam int          BUF_AW        = 5;
  localparam int          BURST_BYTES   = 64;
  localparam logic [31:0] OCM_HADDR_DEF = 32'hfffc0000;
  localparam int          OCM_WIDTH_DEF = 16;

  // Burst byte address; the offset wraps inside a 2^width byte window.
  function automatic logic [31:0] burst_addr(input logic [31:0] base,
                                             input int          width,
                                             input logic [31:0] bcnt);
    logic [31:0] mask;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return base + ((bcnt * 32'(BURST_BYTES)) & mask);
  endfunction

endpackage

// File: rtl/a2s_controller_if.sv
// AXI read address/data handshake bundle between the controller and the interconnect.
interface a2s_controller_if;
  logic [31:0] AXI_raddr;
  logic        AXI_arvalid;
  logic        AXI_arready;
  logic        AXI_rvalid;
  logic        AXI_rready;
  logic        AXI_rlast;

  modport master (
    output AXI_raddr, AXI_arvalid, AXI_rready,
    input  AXI_arready, AXI_rvalid, AXI_rlast
  );

  modport slave (
    input  AXI_raddr, AXI_arvalid, AXI_rready,
    output AXI_arready, AXI_rvalid, AXI_rlast
  );
endinterface

// File: rtl/a2s_controller.sv
// Fetches 64-byte OCM bursts into a 32-word ping-pong buffer and tracks
// the stream consumer reading it back out.
module a2s_controller
  import a2s_pkg::*;
#(
  parameter logic [31:0] ocm_haddr = OCM_HADDR_DEF,
  parameter int          ocm_width = OCM_WIDTH_DEF
) (
  input  logic              AXI_clk,
  input  logic              rst,
  input  logic              sync,
  input  logic              Oen,
  output logic [BUF_AW-1:0] Oaddr,
  output logic              a2s_ready,
  output logic [31:0]       a2s_cnt,
  output logic              a2s_underrun,
  output logic [31:0]       AXI_raddr,
  output logic              AXI_arvalid,
  input  logic              AXI_arready,
  input  logic              AXI_rvalid,
  output logic              AXI_rready,
  input  logic              AXI_rlast,
  output logic [BUF_AW-1:0] a2s_addr,
  output logic              a2s_en,
  output logic              a2s_err
);

  state_e      state_q;
  logic [35:0] cnt_q;
  logic [1:0]  valid_q, valid_d;
  logic [31:0] bcnt_q;
  logic [3:0]  beat_q;
  logic        drain_q, underrun_q, err_q;
  logic        arvalid_q, rready_q;
  logic [31:0] raddr_q;

  logic beat_acc, last_beat, fill_done;

  assign beat_acc  = (state_q == R) && AXI_rvalid;
  assign last_beat = beat_acc && (beat_q == 4'(BURST_LEN - 1));
  // A sync landing on the final beat also discards the burst.
  assign fill_done = last_beat && !drain_q && !sync;

  assign Oaddr        = cnt_q[BUF_AW-1:0];
  assign a2s_cnt      = cnt_q[35:4];
  assign a2s_ready    = valid_q[cnt_q[4]];
  assign a2s_underrun = underrun_q;
  assign a2s_err      = err_q;
  assign AXI_raddr    = raddr_q;
  assign AXI_arvalid  = arvalid_q;
  assign AXI_rready   = rready_q;
  assign a2s_addr     = {bcnt_q[0], beat_q};
  assign a2s_en       = beat_acc && !drain_q;

  // Clear applied before set so a same-half collision leaves the half valid.
  always_comb begin
    valid_d = valid_q;
    if (Oen && (cnt_q[3:0] == 4'hf)) valid_d[cnt_q[4]] = 1'b0;
    if (fill_done)                   valid_d[bcnt_q[0]] = 1'b1;
    if (sync)                        valid_d = '0;
  end

  always_ff @(posedge AXI_clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      valid_q    <= '0;
      bcnt_q     <= '0;
      beat_q     <= '0;
      drain_q    <= 1'b0;
      underrun_q <= 1'b0;
      err_q      <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      raddr_q    <= ocm_haddr;
    end else begin
      valid_q <= valid_d;
      cnt_q   <= sync ? '0 : cnt_q + 36'(Oen);

      if (sync)                   underrun_q <= 1'b0;
      else if (Oen && !a2s_ready) underrun_q <= 1'b1;

      if (beat_acc && (AXI_rlast != (beat_q == 4'(BURST_LEN - 1)))) err_q <= 1'b1;

      if (sync)           bcnt_q <= '0;
      else if (fill_done) bcnt_q <= bcnt_q + 32'd1;

      unique case (state_q)
        IDLE: begin
          if (!valid_q[bcnt_q[0]] && !drain_q && !sync) begin
            state_q   <= AR;
            arvalid_q <= 1'b1;
            raddr_q   <= burst_addr(ocm_haddr, ocm_width, bcnt_q);
          end
        end
        AR: begin
          if (sync) drain_q <= 1'b1;
          if (AXI_arready) begin
            state_q   <= R;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            beat_q    <= '0;
          end
        end
        R: begin
          if (beat_acc) beat_q <= beat_q + 4'd1;
          if (last_beat) begin
            state_q  <= IDLE;
            rready_q <= 1'b0;
            drain_q  <= 1'b0;
          end else if (sync) begin
            drain_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_a2s_controller.sv
// Directed bench: burst table plus hand-written underrun/reset/idle sequences,
// with a second instance using an 8-bit window to observe address wrap.
module tb_a2s_controller;
  import a2s_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1, sync = 1'b0, Oen = 1'b0;
  logic [4:0]  oaddr1, oaddr2, waddr1, waddr2;
  logic        ready1, ready2, under1, under2, en1, en2, err1, err2;
  logic [31:0] cnt1, cnt2;

  a2s_controller_if axi1 ();
  a2s_controller_if axi2 ();

  assign axi2.AXI_arready = axi1.AXI_arready;
  assign axi2.AXI_rvalid  = axi1.AXI_rvalid;
  assign axi2.AXI_rlast   = axi1.AXI_rlast;

  a2s_controller dut1 (
    .AXI_clk(clk), .rst(rst), .sync(sync), .Oen(Oen),
    .Oaddr(oaddr1), .a2s_ready(ready1), .a2s_cnt(cnt1), .a2s_underrun(under1),
    .AXI_raddr(axi1.AXI_raddr), .AXI_arvalid(axi1.AXI_arvalid),
    .AXI_arready(axi1.AXI_arready), .AXI_rvalid(axi1.AXI_rvalid),
    .AXI_rready(axi1.AXI_rready), .AXI_rlast(axi1.AXI_rlast),
    .a2s_addr(waddr1), .a2s_en(en1), .a2s_err(err1)
  );

  a2s_controller #(.ocm_width(8)) dut2 (
    .AXI_clk(clk), .rst(rst), .sync(sync), .Oen(Oen),
    .Oaddr(oaddr2), .a2s_ready(ready2), .a2s_cnt(cnt2), .a2s_underrun(under2),
    .AXI_raddr(axi2.AXI_raddr), .AXI_arvalid(axi2.AXI_arvalid),
    .AXI_arready(axi2.AXI_arready), .AXI_rvalid(axi2.AXI_rvalid),
    .AXI_rready(axi2.AXI_rready), .AXI_rlast(axi2.AXI_rlast),
    .a2s_addr(waddr2), .a2s_en(en2), .a2s_err(err2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;

  typedef struct {
    int          consume, gap, ar_delay, rlast_beat, sync_beat;
    logic [31:0] a1, a2;
    logic        base;
    logic        exp_ready, exp_under, exp_err;
    logic [4:0]  exp_oaddr;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t tv [7];

  task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic consume(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      Oen = 1'b1;
      tick();
      Oen = 1'b0;
      repeat (gap - 1) tick();
    end
  endtask

  task automatic burst(input logic [31:0] a1, input logic [31:0] a2, input logic base,
                       input int ar_delay, input int rlast_beat, input int sync_beat);
    int   w;
    logic exp_en;
    w = 0;
    while (axi1.AXI_arvalid !== 1'b1 && w < 300) begin
      tick();
      w++;
    end
    if (w >= 300) begin
      chk("arvalid_wait", axi1.AXI_arvalid, 1);
      return;
    end
    chk("raddr", axi1.AXI_raddr, a1);
    chk("raddr_w8", axi2.AXI_raddr, a2);
    for (int d = 0; d < ar_delay; d++) begin
      tick();
      chk("arvalid_hold", axi1.AXI_arvalid, 1);
      chk("raddr_hold", axi1.AXI_raddr, a1);
    end
    axi1.AXI_arready = 1'b1;
    tick();
    axi1.AXI_arready = 1'b0;
    #1;
    chk("arvalid_drop", axi1.AXI_arvalid, 0);
    chk("rready", axi1.AXI_rready, 1);
    for (int b = 0; b < 16; b++) begin
      axi1.AXI_rvalid = 1'b1;
      axi1.AXI_rlast  = (b == rlast_beat);
      sync            = (b == sync_beat);
      #1;
      exp_en = (sync_beat < 0) || (b <= sync_beat);
      chk("a2s_en", en1, exp_en);
      if (exp_en) chk("a2s_addr", waddr1, {base, 4'(b)});
      tick();
      sync = 1'b0;
    end
    axi1.AXI_rvalid = 1'b0;
    axi1.AXI_rlast  = 1'b0;
    #1;
  endtask

  task automatic run_vec(input int i);
    fork
      consume(tv[i].consume, tv[i].gap);
      burst(tv[i].a1, tv[i].a2, tv[i].base, tv[i].ar_delay, tv[i].rlast_beat, tv[i].sync_beat);
    join
    #1;
    chk($sformatf("v%0d_ready", i), ready1, tv[i].exp_ready);
    chk($sformatf("v%0d_underrun", i), under1, tv[i].exp_under);
    chk($sformatf("v%0d_oaddr", i), oaddr1, tv[i].exp_oaddr);
    chk($sformatf("v%0d_cnt", i), cnt1, tv[i].exp_cnt);
    chk($sformatf("v%0d_err", i), err1, tv[i].exp_err);
    chk($sformatf("v%0d_err_w8", i), err2, tv[i].exp_err);
  endtask

  initial begin
    int s;
    //          cons gap dly rlast sync  a1            a2            base rdy und err oaddr cnt
    tv[0] = '{0,   1,  0,  15,  -1, 32'hfffc0000, 32'hfffc0000, 1'b0, 1, 0, 0, 5'd0,  32'd0};
    tv[1] = '{0,   1,  0,  15,  -1, 32'hfffc0040, 32'hfffc0040, 1'b1, 1, 0, 0, 5'd0,  32'd0};
    tv[2] = '{48,  4,  0,  15,  -1, 32'hfffc0080, 32'hfffc0080, 1'b0, 0, 0, 0, 5'd16, 32'd3};
    tv[3] = '{0,   1,  0,  15,  -1, 32'hfffc00c0, 32'hfffc00c0, 1'b1, 1, 0, 0, 5'd16, 32'd3};
    tv[4] = '{0,   1,  10, 15,  -1, 32'hfffc0100, 32'hfffc0000, 1'b0, 1, 0, 0, 5'd16, 32'd3};
    tv[5] = '{0,   1,  0,  15,  7,  32'hfffc0140, 32'hfffc0040, 1'b1, 0, 0, 0, 5'd0,  32'd0};
    tv[6] = '{0,   1,  0,  10,  -1, 32'hfffc0000, 32'hfffc0000, 1'b0, 1, 0, 1, 5'd0,  32'd0};

    axi1.AXI_arready = 1'b0;
    axi1.AXI_rvalid  = 1'b0;
    axi1.AXI_rlast   = 1'b0;

    repeat (3) tick();
    #1;
    chk("rst_arvalid", axi1.AXI_arvalid, 0);
    chk("rst_rready", axi1.AXI_rready, 0);
    chk("rst_en", en1, 0);
    chk("rst_raddr", axi1.AXI_raddr, 32'hfffc0000);
    chk("rst_waddr", waddr1, 0);
    chk("rst_ready", ready1, 0);
    chk("rst_cnt", cnt1, 0);
    chk("rst_oaddr", oaddr1, 0);
    chk("rst_underrun", under1, 0);
    chk("rst_err", err1, 0);

    rst  = 1'b0;
    sync = 1'b1;
    tick();
    s    = cyc;
    sync = 1'b0;

    run_vec(0);
    chk("sync_to_ready_le22", 32'((cyc - s) <= 22), 1);
    run_vec(1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("idle_arvalid", axi1.AXI_arvalid, 0);
      chk("idle_rready", axi1.AXI_rready, 0);
    end

    for (int i = 2; i <= 4; i++) run_vec(i);

    // Drain both halves back-to-back while the next fetch is held off.
    consume(32, 1);
    #1;
    chk("drained_ready", ready1, 0);
    chk("drained_underrun", under1, 0);
    chk("drained_oaddr", oaddr1, 5'd16);
    chk("pending_arvalid", axi1.AXI_arvalid, 1);
    consume(1, 1);
    #1;
    chk("underrun_set", under1, 1);
    chk("underrun_oaddr", oaddr1, 5'd17);
    chk("underrun_cnt", cnt1, 32'd5);
    chk("pending_raddr", axi1.AXI_raddr, 32'hfffc0140);

    run_vec(5);
    run_vec(6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
